// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one shared slave bus, with slave-wait timeout.
// Latency: grant one cycle after an IDLE request; completion strobe same cycle as s_ready.
// Backpressure: slave stalls via s_ready=0; a grant holds until done, timeout or withdrawal.
//
// Ports:
//   clk, res                 clock, async active-low reset
//   m0_* / m1_*              requester side (m0 = CPU, m1 = DMA/debug): addr, accessType,
//                            memLen, wdata in; rdata, ready, error out
//   s_*                      shared slave bus: addr, accessType, memLen, wdata out; rdata, ready in
//   owner                    registered grant state: 00 idle, 01 m0, 10 m1

`ifndef MEM_ACCESS
`define MEM_ACCESS        [1:0]
`define MEM_ACCESS_NONE   2'd0
`define MEM_ACCESS_READ   2'd1
`define MEM_ACCESS_WRITE  2'd2
`endif
`ifndef MEM_LEN
`define MEM_LEN           [1:0]
`define MEM_LEN_B         2'd0
`define MEM_LEN_H         2'd1
`define MEM_LEN_W         2'd2
`endif

module bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [31:0]          m0_addr,
  input  logic `MEM_ACCESS     m0_accessType,
  input  logic `MEM_LEN        m0_memLen,
  input  logic [31:0]          m0_wdata,
  output logic [31:0]          m0_rdata,
  output logic                 m0_ready,
  output logic                 m0_error,
  input  logic [31:0]          m1_addr,
  input  logic `MEM_ACCESS     m1_accessType,
  input  logic `MEM_LEN        m1_memLen,
  input  logic [31:0]          m1_wdata,
  output logic [31:0]          m1_rdata,
  output logic                 m1_ready,
  output logic                 m1_error,
  output logic [31:0]          s_addr,
  output logic `MEM_ACCESS     s_accessType,
  output logic `MEM_LEN        s_memLen,
  output logic [31:0]          s_wdata,
  input  logic [31:0]          s_rdata,
  input  logic                 s_ready,
  output logic [1:0]           owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t     state;
  logic       last_served;  // 0 = m0, 1 = m1
  logic [7:0] wait_cnt;
  logic       arb_en;       // low for the first edge after reset release

  logic m0_req, m1_req, pick_m0;
  logic in_grant, cur_req, done, withdraw, timeout;

  assign m0_req  = (m0_accessType != `MEM_ACCESS_NONE);
  assign m1_req  = (m1_accessType != `MEM_ACCESS_NONE);
  // Contention goes to whichever master was not served last.
  assign pick_m0 = m0_req && (!m1_req || last_served);

  assign in_grant = (state != IDLE);
  assign cur_req  = (state == GRANT0) ? m0_req : ((state == GRANT1) ? m1_req : 1'b0);
  // s_ready wins over timeout; a withdrawn request aborts silently.
  assign done     = in_grant && s_ready;
  assign withdraw = in_grant && !s_ready && !cur_req;
  assign timeout  = in_grant && !s_ready && cur_req && (wait_cnt == TIMEOUT - 8'd1);

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_ready = (state == GRANT0) && (done || timeout);
  assign m1_ready = (state == GRANT1) && (done || timeout);
  assign m0_error = (state == GRANT0) && timeout;
  assign m1_error = (state == GRANT1) && timeout;

  always_comb begin
    s_addr       = 32'd0;
    s_accessType = `MEM_ACCESS_NONE;
    s_memLen     = `MEM_LEN_W;
    s_wdata      = 32'd0;
    if (state == GRANT0) begin
      s_addr       = m0_addr;
      s_accessType = m0_accessType;
      s_memLen     = m0_memLen;
      s_wdata      = m0_wdata;
    end else if (state == GRANT1) begin
      s_addr       = m1_addr;
      s_accessType = m1_accessType;
      s_memLen     = m1_memLen;
      s_wdata      = m1_wdata;
    end
    // Pull the access off the bus on the cycle the wait gives up.
    if (timeout) s_accessType = `MEM_ACCESS_NONE;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= IDLE;
      last_served <= 1'b1;
      wait_cnt    <= 8'd0;
      owner       <= 2'b00;
      arb_en      <= 1'b0;
    end else begin
      arb_en <= 1'b1;
      if (state == IDLE) begin
        if (arb_en && (m0_req || m1_req)) begin
          wait_cnt <= 8'd0;
          if (pick_m0) begin
            state       <= GRANT0;
            owner       <= 2'b01;
            last_served <= 1'b0;
          end else begin
            state       <= GRANT1;
            owner       <= 2'b10;
            last_served <= 1'b1;
          end
        end
      end else if (done || withdraw || timeout) begin
        state <= IDLE;
        owner <= 2'b00;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (TIMEOUT = 4): directed cycle table, reset corner sequence,
// then randomized traffic against a transaction-level reference model.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.

`ifndef MEM_ACCESS
`define MEM_ACCESS        [1:0]
`define MEM_ACCESS_NONE   2'd0
`define MEM_ACCESS_READ   2'd1
`define MEM_ACCESS_WRITE  2'd2
`endif
`ifndef MEM_LEN
`define MEM_LEN           [1:0]
`define MEM_LEN_B         2'd0
`define MEM_LEN_H         2'd1
`define MEM_LEN_W         2'd2
`endif

module tb_bus_arbiter;

  localparam logic [7:0] TO = 8'd4;
  localparam logic [1:0] NA = 2'd0, RD = 2'd1, WR = 2'd2;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0, m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic [1:0]  m0_acc = NA, m1_acc = NA, m0_len = 2'd2, m1_len = 2'd2;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [31:0] s_rdata = 32'h0;
  logic        s_ready = 1'b0;
  logic        m0_ready, m1_ready, m0_error, m1_error;
  logic [1:0]  s_acc, s_len, owner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_accessType(m0_acc), .m0_memLen(m0_len), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_addr(m1_addr), .m1_accessType(m1_acc), .m1_memLen(m1_len), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
    .s_addr(s_addr), .s_accessType(s_acc), .s_memLen(s_len), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .owner(owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the bus, how many grant cycles it has had (1-based),
  // who was served last, and whether an edge has passed since reset release.
  int mdl_own;    // 0 none, 1 m0, 2 m1
  int mdl_age;
  int mdl_last;   // 1 = m0, 2 = m1
  bit mdl_armed;

  task automatic model_reset();
    mdl_own = 0; mdl_age = 0; mdl_last = 2; mdl_armed = 1'b0;
  endtask

  task automatic model_edge();
    bit r0, r1, rx;
    r0 = (m0_acc != NA);
    r1 = (m1_acc != NA);
    if (mdl_own == 0) begin
      if (mdl_armed && (r0 || r1)) begin
        if (r0 && r1) mdl_own = (mdl_last == 1) ? 2 : 1;
        else          mdl_own = r0 ? 1 : 2;
        mdl_last = mdl_own;
        mdl_age  = 1;
      end
    end else begin
      rx = (mdl_own == 1) ? r0 : r1;
      if (s_ready || !rx || mdl_age == int'(TO)) mdl_own = 0;
      else mdl_age++;
    end
    mdl_armed = 1'b1;
  endtask

  task automatic model_check();
    bit rx, tmo;
    logic [31:0] ea, ew;
    logic [1:0]  eacc, elen;
    rx  = (mdl_own == 1) ? (m0_acc != NA) : (mdl_own == 2) ? (m1_acc != NA) : 1'b0;
    tmo = (mdl_own != 0) && !s_ready && rx && (mdl_age == int'(TO));
    ea = 32'h0; ew = 32'h0; eacc = NA; elen = 2'd2;
    if (mdl_own == 1) begin ea = m0_addr; ew = m0_wdata; eacc = m0_acc; elen = m0_len; end
    if (mdl_own == 2) begin ea = m1_addr; ew = m1_wdata; eacc = m1_acc; elen = m1_len; end
    if (tmo) eacc = NA;
    chk("rnd_owner", {30'd0, owner}, mdl_own);
    chk("rnd_s_addr", s_addr, ea);
    chk("rnd_s_acc", {30'd0, s_acc}, {30'd0, eacc});
    chk("rnd_s_len", {30'd0, s_len}, {30'd0, elen});
    chk("rnd_s_wdata", s_wdata, ew);
    chk("rnd_m0_ready", {31'd0, m0_ready}, {31'd0, (mdl_own == 1) && (s_ready || tmo)});
    chk("rnd_m1_ready", {31'd0, m1_ready}, {31'd0, (mdl_own == 2) && (s_ready || tmo)});
    chk("rnd_m0_error", {31'd0, m0_error}, {31'd0, (mdl_own == 1) && tmo});
    chk("rnd_m1_error", {31'd0, m1_error}, {31'd0, (mdl_own == 2) && tmo});
    chk("rnd_rdata", m0_rdata ^ m1_rdata ^ s_rdata, s_rdata);
  endtask

  typedef struct {
    logic [1:0] m0a, m1a;
    logic       sr;
    logic [1:0] e_own, e_sacc;
    logic       e_m0r, e_m0e, e_m1r, e_m1e;
  } vec_t;

  vec_t tbl[21];

  task automatic do_reset();
    res = 1'b0;
    m0_acc = RD; m1_acc = WR; s_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_s_acc", {30'd0, s_acc}, {30'd0, NA});
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_len", {30'd0, s_len}, 32'd2);
    chk("rst_ready", {30'd0, m0_ready, m1_ready}, 32'd0);
    chk("rst_error", {30'd0, m0_error, m1_error}, 32'd0);
    m0_acc = NA; m1_acc = NA; s_ready = 1'b0;
    @(posedge clk);
    #1 res = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] ea;
    // Contention from reset, alternation, timeout, withdrawal, coincidence, idle s_ready.
    tbl[0]  = '{RD, WR, 1'b0, 2'd0, NA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{RD, WR, 1'b0, 2'd0, NA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{RD, WR, 1'b0, 2'd1, RD, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{RD, WR, 1'b1, 2'd1, RD, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{RD, WR, 1'b0, 2'd0, NA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{RD, WR, 1'b1, 2'd2, WR, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{RD, WR, 1'b0, 2'd0, NA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{RD, WR, 1'b0, 2'd1, RD, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{RD, WR, 1'b0, 2'd1, RD, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{RD, WR, 1'b0, 2'd1, RD, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{RD, WR, 1'b0, 2'd1, NA, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{RD, WR, 1'b0, 2'd0, NA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{RD, WR, 1'b0, 2'd2, WR, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{RD, NA, 1'b0, 2'd2, NA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{RD, NA, 1'b0, 2'd0, NA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{RD, NA, 1'b0, 2'd1, RD, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{RD, NA, 1'b0, 2'd1, RD, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{RD, NA, 1'b0, 2'd1, RD, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{RD, NA, 1'b1, 2'd1, RD, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{NA, NA, 1'b0, 2'd0, NA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{NA, NA, 1'b1, 2'd0, NA, 1'b0, 1'b0, 1'b0, 1'b0};

    m0_addr = 32'h8000_0000; m0_len = 2'd2; m0_wdata = 32'h1111_2222;
    m1_addr = 32'h4000_1000; m1_len = 2'd0; m1_wdata = 32'hA5A5_5A5A;
    do_reset();

    for (int i = 0; i < 21; i++) begin
      m0_acc = tbl[i].m0a; m1_acc = tbl[i].m1a; s_ready = tbl[i].sr;
      s_rdata = $urandom;
      @(negedge clk);
      ea = (tbl[i].e_own == 2'd1) ? m0_addr : (tbl[i].e_own == 2'd2) ? m1_addr : 32'h0;
      chk($sformatf("vec%0d_owner", i), {30'd0, owner}, {30'd0, tbl[i].e_own});
      chk($sformatf("vec%0d_s_acc", i), {30'd0, s_acc}, {30'd0, tbl[i].e_sacc});
      chk($sformatf("vec%0d_s_addr", i), s_addr, ea);
      chk($sformatf("vec%0d_rdy_err", i), {28'd0, m0_ready, m0_error, m1_ready, m1_error},
          {28'd0, tbl[i].e_m0r, tbl[i].e_m0e, tbl[i].e_m1r, tbl[i].e_m1e});
      chk($sformatf("vec%0d_rdata", i), m0_rdata & m1_rdata, s_rdata);
      @(posedge clk);
      #1;
    end

    // Reset asserted during GRANT1 abandons the transfer at once.
    m0_acc = NA; m1_acc = WR; s_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_owner_granted", {30'd0, owner}, 32'd2);
    #2 res = 1'b0; s_ready = 1'b1;
    #1;
    chk("mid_owner_async", {30'd0, owner}, 32'd0);
    chk("mid_s_acc_async", {30'd0, s_acc}, {30'd0, NA});
    chk("mid_m1_ready", {31'd0, m1_ready}, 32'd0);
    @(posedge clk);
    #1 res = 1'b1; s_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_edge1_owner", {30'd0, owner}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_edge2_owner", {30'd0, owner}, 32'd2);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      if ($urandom_range(4) == 0) m0_acc = 2'($urandom_range(2));
      if ($urandom_range(4) == 0) m1_acc = 2'($urandom_range(2));
      m0_addr = $urandom; m1_addr = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_len = 2'($urandom_range(2)); m1_len = 2'($urandom_range(2));
      s_ready = ($urandom_range(3) == 0);
      s_rdata = $urandom;
      @(negedge clk);
      model_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
